shift_sub_div: RTL
==================

# shift_sub_div

Sequential restoring shift-subtract divider, the inverse companion of the team's shift-add multiplier. Produces quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per cycle. Uses the same start/valid_in/busy/done/valid_out handshake and optional signed mode as the multiplier, so both blocks can share an arithmetic-unit wrapper.

## Interface
- WIDTH, 16, operand, quotient and remainder width (≥2)
- SIGNED, 1, 1 enables two's-complement support via signed_mode; 0 forces unsigned
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a division (qualified by valid_in)
- valid_in  input  1  operands valid
- dividend  input  WIDTH  dividend
- divisor  input  WIDTH  divisor
- signed_mode  input  1  1 = signed operation (effective only when SIGNED=1)
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- valid_out  output  1  one-cycle pulse, results valid
- done  output  1  one-cycle pulse, coincident with valid_out
- busy  output  1  high while an operation is in flight
- div_by_zero  output  1  registered with results; divisor was zero

## Operation
- States: IDLE, DIVIDE, FINISH.
- IDLE: valid_out and done are driven 0. On start && valid_in:
  - Capture operands.
  - Record the quotient sign (dividend MSB ^ divisor MSB) and the remainder sign (dividend MSB) when signed.
  - Load the magnitudes: dividend magnitude into the quotient shift register, divisor magnitude into the divisor register.
  - Clear the (WIDTH+1)-bit partial remainder, clear the counter, set busy, go to DIVIDE.
- DIVIDE, per cycle:
  - s = {rem[WIDTH-1:0], q[WIDTH-1]}
  - d = s − {0, divisor}
  - If d ≥ 0: rem = d, q = {q[WIDTH-2:0], 1}. Otherwise: rem = s, q = {q[WIDTH-2:0], 0}.
  - After WIDTH iterations (counter == WIDTH−1), go to FINISH.
- FINISH:
  - Negate the quotient if its sign flag is set; negate the remainder if its sign flag is set.
  - Register quotient, remainder and div_by_zero.
  - Pulse valid_out and done, clear busy, return to IDLE.
- Signed semantics: truncating division. Remainder takes the sign of the dividend.
  - Most-negative ÷ −1 wraps: quotient = 0x8000 (WIDTH=16), remainder = 0.
- start while not in IDLE is ignored. Operands need to be stable only in the accept cycle.
- quotient, remainder and div_by_zero hold their value until the next FINISH.

## Timing
- Reset: state IDLE; quotient, remainder, valid_out, done, busy and div_by_zero all 0; internal registers cleared.
- Accept edge E0. busy is high after E0.
- DIVIDE occupies edges E1..E_WIDTH. The FINISH edge is E_WIDTH+1, after which results, valid_out and done are high for one cycle and busy is 0.
- Latency: the result is visible WIDTH+2 cycles after the accept cycle.
- A new start is accepted one cycle after done (back-to-back throughput WIDTH+2 cycles).
- rst asserted mid-operation: next edge returns to IDLE with all outputs 0; the in-flight operation is discarded.
- rst has priority over start.

## Configuration
- Macro: SHIFT_SUB_DIV_ZERO_DETECT_EN.
- Defined:
  - Divisor == 0 at accept sets a flag and goes straight from IDLE to FINISH, so the result is visible 2 cycles after accept.
  - FINISH outputs quotient = all ones, remainder = raw dividend (no sign correction), div_by_zero = 1.
- Undefined:
  - div_by_zero is tied 0.
  - A zero divisor runs the full WIDTH iterations. Quotient and remainder are not specified; only the handshake timing is guaranteed.

## Structure
- Package shift_div_pkg holds:
  - the state enum typedef (IDLE/DIVIDE/FINISH);
  - the state-width localparam;
  - a function computing counter width from WIDTH.
- One sub-module, div_sign_conv: a combinational conditional two's-complement negator (in: value, neg; out: value or −value).
  - Three instances: dividend magnitude, divisor magnitude, output correction (time-shared quotient/remainder or two instances; implementer's choice).
- The divider FSM and datapath stay in shift_sub_div.

## Test plan
All scenarios use WIDTH=16.
- Unsigned 100 ÷ 7, signed_mode=0 -> quotient 14, remainder 2, valid_out exactly 18 cycles after the accept cycle, busy high throughout.
- Signed −100 ÷ 7 (0xFF9C, 0x0007) -> quotient 0xFFF2 (−14), remainder 0xFFFE (−2); 100 ÷ −7 -> quotient 0xFFF2, remainder 0x0002.
- Boundaries:
  - unsigned 0xFFFF ÷ 0x0001 -> 0xFFFF r 0;
  - signed 0x8000 ÷ 0xFFFF -> 0x8000 r 0;
  - 5 ÷ 9 -> 0 r 5.
- With SHIFT_SUB_DIV_ZERO_DETECT_EN, 1234 ÷ 0 -> quotient 0xFFFF, remainder 0x04D2, div_by_zero 1, valid_out 2 cycles after accept. Without the macro: div_by_zero stays 0, latency 18.
- Handshake:
  - start pulses while busy are ignored;
  - start with valid_in=0 is ignored;
  - back-to-back operations (start in the cycle after done) both return correct results.
- Assert rst at cycle 5 of DIVIDE -> next cycle all outputs 0, state IDLE. A fresh 81 ÷ 9 then yields 9 r 0.

Source files
------------

// File: rtl/shift_div_pkg.sv
// Shared types and helpers for the shift-subtract divider.
// Build option (in shift_sub_div): SHIFT_SUB_DIV_ZERO_DETECT_EN.
package shift_div_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } div_state_t;

  // Iteration counter must reach WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/div_sign_conv.sv
// Conditional two's-complement negator: result = neg ? -value : value.
module div_sign_conv #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  input  logic             neg,
  output logic [WIDTH-1:0] result
);

  assign result = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/shift_sub_div.sv
// Sequential restoring divider, one quotient bit per cycle, optional signed mode.
// Build option: define SHIFT_SUB_DIV_ZERO_DETECT_EN to short-cut zero divisors.
module shift_sub_div
  import shift_div_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid_out,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t state_reg, state_next;

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] dvs_reg;
  // The restored partial remainder is always below the divisor, so its
  // (WIDTH+1)th bit is provably zero and is not stored.
  logic [WIDTH-1:0] rem_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             q_neg_reg;
  logic             r_neg_reg;
  logic             busy_reg;
  logic             valid_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;

  logic             accept;
  logic             signed_eff;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] q_fixed;
  logic [WIDTH-1:0] r_fixed;

  logic [WIDTH:0]   s_val;
  logic [WIDTH-1:0] d_low;
  logic             ge;
  logic [WIDTH-1:0] rem_new;

  assign signed_eff = SIGNED & signed_mode;
  assign dvd_neg    = signed_eff & dividend[WIDTH-1];
  assign dvs_neg    = signed_eff & divisor[WIDTH-1];

  div_sign_conv #(.WIDTH(WIDTH)) u_dvd_mag (.value(dividend), .neg(dvd_neg), .result(dvd_mag));
  div_sign_conv #(.WIDTH(WIDTH)) u_dvs_mag (.value(divisor),  .neg(dvs_neg), .result(dvs_mag));
  div_sign_conv #(.WIDTH(WIDTH)) u_q_fix   (.value(q_reg),    .neg(q_neg_reg), .result(q_fixed));
  div_sign_conv #(.WIDTH(WIDTH)) u_r_fix   (.value(rem_reg),  .neg(r_neg_reg), .result(r_fixed));

  // Trial subtraction; when it succeeds the difference fits in WIDTH bits.
  assign s_val   = {rem_reg, q_reg[WIDTH-1]};
  assign ge      = (s_val >= {1'b0, dvs_reg});
  assign d_low   = s_val[WIDTH-1:0] - dvs_reg;
  assign rem_new = ge ? d_low : s_val[WIDTH-1:0];

`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  logic             dz_flag_reg;
  logic [WIDTH-1:0] raw_dvd_reg;
  logic             dbz_reg;
`endif

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && valid_in) begin
          accept = 1'b1;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
          state_next = (divisor == '0) ? FINISH : DIVIDE;
`else
          state_next = DIVIDE;
`endif
        end
      end
      DIVIDE:  if (cnt_reg == LAST_CNT) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg         <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      q_neg_reg     <= 1'b0;
      r_neg_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
      dz_flag_reg   <= 1'b0;
      raw_dvd_reg   <= '0;
      dbz_reg       <= 1'b0;
`endif
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            q_reg     <= dvd_mag;
            dvs_reg   <= dvs_mag;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            q_neg_reg <= dvd_neg ^ dvs_neg;
            r_neg_reg <= dvd_neg;
            busy_reg  <= 1'b1;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
            dz_flag_reg <= (divisor == '0);
            raw_dvd_reg <= dividend;
`endif
          end
        end
        DIVIDE: begin
          rem_reg <= rem_new;
          q_reg   <= {q_reg[WIDTH-2:0], ge};
          cnt_reg <= cnt_reg + 1'b1;
        end
        FINISH: begin
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
          quotient_reg  <= dz_flag_reg ? '1 : q_fixed;
          remainder_reg <= dz_flag_reg ? raw_dvd_reg : r_fixed;
          dbz_reg       <= dz_flag_reg;
`else
          quotient_reg  <= q_fixed;
          remainder_reg <= r_fixed;
`endif
        end
        default: ;
      endcase
    end
  end

  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign valid_out = valid_reg;
  assign done      = valid_reg;
  assign busy      = busy_reg;
`ifdef SHIFT_SUB_DIV_ZERO_DETECT_EN
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
